// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer sitting directly behind the UART receiver. A small capture
//   FSM takes each completed byte (plus its parity status), pushes it into a
//   first-word-fall-through FIFO and returns a one-cycle acknowledge. The
//   register-control block drains the FIFO with a pop strobe and watches the
//   level, sticky overflow, idle timeout and combined interrupt.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   rx_ok             : receiver byte-ready level (held until acknowledged)
//   rxd_out           : received byte, valid while rx_ok=1
//   parity_error      : parity status of the current byte
//   rd_data_flag      : one-cycle acknowledge to the receiver
//   pop               : consume the head entry
//   flush             : empty the FIFO
//   clr_ovf           : clear the sticky overflow flag
//   thresh            : interrupt level threshold (0 disables that term)
//   head_data         : head entry {parity_err, byte}, 0 when empty
//   empty, full       : FIFO occupancy flags
//   level             : number of stored entries, 0..DEPTH
//   overflow          : sticky, set when a byte is dropped
//   timeout           : non-empty and idle for TO_CYCLES clocks
//   irq               : threshold | timeout | overflow

module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int TO_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_ok,
    input  logic [7:0]    rxd_out,
    input  logic          parity_error,
    output logic          rd_data_flag,
    input  logic          pop,
    input  logic          flush,
    input  logic          clr_ovf,
    input  logic [AW:0]   thresh,
    output logic [8:0]    head_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          timeout,
    output logic          irq
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [15:0] TO_MAX  = 16'(TO_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t state;
    state_t state_next;

    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [15:0]   idle_cnt;

    // ------------------------------------------------------------------
    // Capture FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture FSM: next-state logic
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (rx_ok) state_next = ACK;
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!rx_ok) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Capture FSM: outputs
    always_comb begin
        push_req     = 1'b0;
        rd_data_flag = 1'b0;
        case (state)
            IDLE:    push_req     = rx_ok;
            ACK:     rd_data_flag = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // Flush overrides everything: a captured byte in the same cycle is lost
    // (but still acknowledged) and is not counted as an overflow.
    // A pop at full frees the slot the simultaneous push writes into.
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push_req && !flush && (!full || do_pop);
    assign drop    = push_req && !flush && full && !do_pop;

    // NOTE: the storage array has no reset; only pointers and level define
    // which entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= {parity_error, rxd_out};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Idle counter: restarts on any FIFO activity or while empty, then
    // saturates at TO_MAX so timeout stays asserted until serviced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (flush || do_push || do_pop || empty) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TO_MAX) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs derived from registered state only
    // ------------------------------------------------------------------
    assign head_data = empty ? 9'h000 : mem[rptr];
    assign timeout   = (idle_cnt == TO_MAX);
    assign irq       = ((thresh != '0) && (level >= thresh)) || timeout || overflow;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer directly downstream of the UART receiver. It captures each completed byte (with its parity-error status) from the receiver's `rx_ok`/`rxd_out`/`parity_error` outputs and returns the `rd_data_flag` acknowledge. Captured bytes are stored in a first-word-fall-through FIFO, which the register-control block drains through a pop strobe. It reports fill level, a sticky overflow flag, an idle timeout and a combined interrupt, so software no longer has to service every byte before the next one arrives.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; power of two, 2..256.
- `AW`, default 4: log2(`DEPTH`).
- `TO_CYCLES`, default 1024: idle clocks before timeout asserts; range 1..65535.

Ports:
- `clk` in 1: single clock; same domain as the receiver (`uart_gate_clk`).
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_ok` in 1: receiver byte-ready level; held high until acknowledged.
- `rxd_out` in 8: received byte; valid while `rx_ok`=1.
- `parity_error` in 1: parity status of the current byte; valid while `rx_ok`=1.
- `rd_data_flag` out 1: one-cycle acknowledge pulse to the receiver.
- `pop` in 1: consume the head entry.
- `flush` in 1: empty the FIFO.
- `clr_ovf` in 1: clear the sticky overflow flag.
- `thresh` in AW+1: interrupt level threshold; 0 disables the threshold term.
- `head_data` out 9: head entry as {parity_err, byte}; 0 when empty.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `level` out AW+1: entry count, 0..`DEPTH`.
- `overflow` out 1: sticky; set when a byte is dropped.
- `timeout` out 1: FIFO non-empty and idle for `TO_CYCLES` clocks.
- `irq` out 1: interrupt request.

## Operation
- Capture FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE: when `rx_ok`=1, push {`parity_error`, `rxd_out`} at this edge, then go to ACK.
  - ACK: drive `rd_data_flag`=1 for exactly one cycle, then go to WAIT_LOW.
  - WAIT_LOW: stay until `rx_ok`=0, then go to IDLE. This guarantees one push per byte even if the receiver is slow to drop `rx_ok`.
- Storage: memory array with AW-bit read and write pointers that wrap naturally modulo `DEPTH`, plus an AW+1-bit `level` counter.
- `head_data` = mem[rptr] when not empty, else 0 (combinational from registered state).
- Push when full: the byte is dropped, `overflow` is set, and the byte is still acknowledged so the receiver never stalls.
- Push and pop in the same cycle while full: both succeed; `level` is unchanged and `overflow` is not set.
- Pop when empty: ignored; pointers and `level` unchanged.
- `flush`: pointers and `level` go to 0 and `timeout` clears. `flush` beats a same-cycle push; that byte is lost but acknowledged, and `overflow` is not set. `flush` does not clear `overflow`.
- `clr_ovf`: clears `overflow`. If a drop occurs in the same cycle, set wins.
- Timeout counter (16 bit):
  - Resets to 0 on any push, pop, flush, or when `empty`.
  - Otherwise increments, saturating at `TO_CYCLES`.
  - `timeout` = (counter == `TO_CYCLES`).
- `irq` = (`thresh` != 0 && `level` >= `thresh`) | `timeout` | `overflow`.

## Timing
- Reset (`rst_n`=0 at an edge):
  - FSM to IDLE; pointers, `level` and timeout counter to 0; memory contents not reset.
  - Outputs: `rd_data_flag`=0, `empty`=1, `full`=0, `level`=0, `head_data`=0, `overflow`=0, `timeout`=0, `irq`=0.
- Reset mid-handshake: the FSM returns to IDLE. If `rx_ok` is still high after reset, that byte is captured again (accepted duplicate).
- Push latency: with `rx_ok` high in IDLE at edge N, `level`, `empty` and `head_data` update after edge N; `rd_data_flag` is high during cycle N+1 only.
- Minimum spacing between captures: 3 cycles (IDLE→ACK→WAIT_LOW→IDLE with `rx_ok` low for at least one sampled edge).
- Pop: `head_data` is valid combinationally whenever `empty`=0. `pop` at edge M advances `rptr`; the next entry is visible after edge M.
- All status outputs (`empty`, `full`, `level`, `overflow`, `timeout`, `irq`) are registered or derived from registers only; no combinational path exists from `pop`, `flush` or `rx_ok` to any output.

## Test plan
- Single byte: reset, then drive `rx_ok`=1 with 0xA5, `parity_error`=0, holding 5 cycles. Expect exactly one `rd_data_flag` pulse, `level`=1, `head_data`=0x0A5. Pop, then expect `empty`=1 and `head_data`=0.
- Fill and overflow: push 17 bytes 0x00..0x10 with `DEPTH`=16. Expect `full`=1, `overflow`=1, and 17 acknowledges. Popping 16 returns 0x00..0x0F in order; 0x10 is absent.
- Wrap and parity: push 10, pop 10, then push 12 with the 5th flagged as a parity error. Expect 12 pops in order with bit 8 set only on the 5th.
- Simultaneous push and pop at full: `level` stays 16, `overflow` stays 0, and the popped and appended values are correct.
- Threshold and timeout: `thresh`=4, `TO_CYCLES`=8.
  - Three bytes: `irq`=0 until 8 idle cycles, then `timeout`=1 and `irq`=1; a pop clears `timeout`.
  - A fourth byte: `irq`=1 from the level term.
- Flush and clear collisions:
  - `flush` in the same cycle as a capture: `level`=0, byte acknowledged, `overflow` unchanged.
  - `clr_ovf` in the same cycle as a drop: `overflow` remains 1.
